// File: rtl/cdc_pulse_pacer.sv
// Source-domain pacer: queues bursty events and re-issues them as spaced
// single-cycle pulses. Optional macro: CDC_PULSE_PACER_DROP_CNT_EN.
module cdc_pulse_pacer #(
    parameter int PEND_WIDTH = 8,
    parameter int GAP_WIDTH  = 10
) (
    input  logic                  clk_src,
    input  logic                  rst_n_src,
    input  logic                  event_in,
    input  logic                  en,
    input  logic [GAP_WIDTH-1:0]  cfg_gap_val,
    input  logic                  clr_ovf,
    output logic                  pulse_out,
    output logic [PEND_WIDTH-1:0] pending_cnt,
    output logic                  busy,
    output logic                  ovf,
    output logic [7:0]            drop_cnt
);

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = 1;
    localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = 1;

    state_t                  state_q, state_d;
    logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
    logic [PEND_WIDTH-1:0]   pend_q, pend_d;
    logic                    pulse_q, pulse_d;
    logic                    ovf_q, ovf_d;
    logic                    issue;
    logic                    drop;
    logic                    pend_full;

    // Issue decision, queue accounting and spacing FSM next state.
    always_comb begin
        pend_full = (pend_q == PEND_MAX);
        issue     = (state_q == IDLE) && en &&
                    ((pend_q != '0) || event_in);
        drop      = event_in && pend_full && !issue;

        // Event+issue together leave the count unchanged (incl. bypass).
        pend_d = pend_q;
        if (event_in && !issue && !pend_full) begin
            pend_d = pend_q + PEND_ONE;
        end else if (!event_in && issue) begin
            pend_d = pend_q - PEND_ONE;
        end

        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = GAP;
                    gap_cnt_d = cfg_gap_val;
                end
            end
            GAP: begin
                // A loaded gap of 0 behaves like 1: minimum period is 2.
                if (gap_cnt_q <= GAP_ONE) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
        endcase

        pulse_d = issue;
        // A drop in the same cycle as a clear keeps the sticky bit set.
        ovf_d   = drop || (ovf_q && !clr_ovf);
    end

    // Core state registers.
    always_ff @(posedge clk_src or negedge rst_n_src) begin
        if (!rst_n_src) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            pend_q    <= '0;
            pulse_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            pend_q    <= pend_d;
            pulse_q   <= pulse_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign pending_cnt = pend_q;
    assign busy        = (pend_q != '0) || (state_q != IDLE);
    assign ovf         = ovf_q;

`ifdef CDC_PULSE_PACER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop during a clear restarts it at 1.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (clr_ovf) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_ovf) begin
            drop_cnt_d = 8'd0;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_src or negedge rst_n_src) begin
        if (!rst_n_src) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
